ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: serializes one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the game logic onto the open-drain keyboard clock/data lines, following the PS/2 host request-to-send sequence. It is the counterpart of the keyboard bit receiver. It shares the kbd_clk/kbd_dat pins through open-drain output enables, and it flags itself busy so the top level can ignore receiver output during a transmission.

## Interface
- INHIBIT_CYCLES, 5000: clk cycles the host holds kbd_clk low before requesting to send (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: watchdog limit from request to completion (15 ms at 50 MHz).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- din  in  8  command byte.
- din_valid  in  1  start request; accepted only while tx_ready=1.
- tx_ready  out  1  1 in IDLE.
- tx_busy  out  1  1 in any state other than IDLE.
- tx_done  out  1  one-cycle pulse at the end of a frame.
- tx_ack_ok  out  1  device ACK result; valid while tx_done=1.
- tx_err  out  1  one-cycle watchdog timeout pulse.
- kbd_clk  in  1  raw PS/2 clock line (asynchronous).
- kbd_dat  in  1  raw PS/2 data line (asynchronous).
- kbd_clk_oe  out  1  1 pulls the clock line low; 0 releases it.
- kbd_dat_oe  out  1  1 pulls the data line low; 0 releases it.

## Operation
- Inputs pass through a 2-flop synchronizer. A falling edge (fall) is sync_prev=1 and sync_now=0.
- Accept: din_valid=1 in IDLE latches din into sh[8:0] = {~^din, din}, so the parity bit is odd parity. cnt is cleared. Next state is INHIBIT.
- INHIBIT:
  - kbd_clk_oe=1 and kbd_dat_oe=0.
  - After INHIBIT_CYCLES cycles, go to REQ.
- REQ:
  - kbd_dat_oe=1 (start bit 0) and kbd_clk_oe=0.
  - Wait for a fall on clk.
  - On the fall, drive sh[0]: kbd_dat_oe = ~sh[0]. Shift sh right, cnt=1, go to DATA.
- DATA:
  - On each fall, drive the next bit: kbd_dat_oe = ~sh[0], shift, cnt+1.
  - Falls 1–8 carry din[0..7] (LSB first). Fall 9 carries parity.
  - Fall 10 releases data (stop bit 1) and goes to ACK.
  - Data changes only on falls; the device samples on rising edges.
- ACK: on the next fall (fall 11), capture ack = ~sync_dat, then go to WAIT_IDLE.
- WAIT_IDLE: when synced clock=1 and data=1, pulse tx_done with tx_ack_ok=ack and return to IDLE.
- din_valid outside IDLE is ignored (no queueing).
- A data value of 1 is never actively driven; it only releases the line. kbd_clk_oe=1 only in INHIBIT.

## Timing
- Reset values: kbd_clk_oe=0, kbd_dat_oe=0, tx_done=0, tx_ack_ok=0, tx_err=0. State=IDLE, so tx_ready=1 and tx_busy=0.
- Reset asserted mid-frame: both lines are released at the first clk edge with reset=1. No tx_done or tx_err is produced.
- Accept cycle N: kbd_clk_oe=1 from N+1 through N+INHIBIT_CYCLES. kbd_dat_oe=1 and kbd_clk_oe=0 at N+INHIBIT_CYCLES+1.
- Pin-to-response latency: 3 clk cycles (2 sync flops plus 1 register) from a raw kbd_clk fall to the kbd_dat_oe update.
- tx_done is exactly 1 cycle wide and arrives 1 cycle after both synced lines read high in WAIT_IDLE.
- tx_ready is low from the cycle after accept until the cycle after tx_done or tx_err.
- The inhibit counter is sized $clog2(INHIBIT_CYCLES+1). The watchdog counter is sized $clog2(TIMEOUT_CYCLES+1). cnt is 4 bits.

## Configuration
- PS2_HOST_TX_TIMEOUT_EN defined:
  - The watchdog counts from entry to REQ.
  - If it reaches TIMEOUT_CYCLES before tx_done, the block releases both lines, pulses tx_err for 1 cycle, leaves tx_done low, and returns to IDLE.
  - If completion and timeout fall in the same cycle, completion wins.
- Not defined: there is no watchdog and tx_err is tied to 0. The FSM waits indefinitely for device clocks.

## Structure
- ps2_pkg holds:
  - typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE} ps2_tx_st_t;
  - PS2_FRAME_BITS=11 and PS2_DATA_BITS=8.
- Sub-module ps2_line_sync: 2-flop synchronizer plus falling-edge detector. It is instantiated once per line and can be reused by the receiver.

## Test plan
- din=0xED with a device model that clocks at 12.5 kHz and ACKs:
  - kbd_clk held low for exactly 5000 cycles.
  - Device-sampled bits: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done=1 and tx_ack_ok=1.
- din=0x02:
  - Sampled parity 0.
  - Device withholds the ACK (data high at fall 11), so tx_done=1 with tx_ack_ok=0.
- din_valid pulsed again at cycle 10 of INHIBIT with din=0xFF: ignored, and the frame still carries the first byte.
- reset=1 during DATA after fall 4: kbd_clk_oe=0 and kbd_dat_oe=0 on the next edge, tx_ready=1 after release, no tx_done.
- Macro on, device never clocks: tx_err pulse exactly TIMEOUT_CYCLES after REQ entry, lines released, tx_done stays 0.
- Back-to-back frames 0xED then 0x07, with din_valid asserted in the cycle after tx_done: both frames are correct and each produces exactly one tx_done pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmitter and the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE} ps2_tx_st_t;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_DATA_BITS  = 8;

    // PS/2 parity makes the total count of ones in data plus parity odd
    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge detector.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_raw,
    output logic sync_now,
    output logic fall_c
);

    logic meta_q, meta_d;
    logic now_q,  now_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = line_raw;
        now_d  = meta_q;
        prev_d = now_q;
    end

    // Idle lines float high, so reset to 1 to avoid a false fall after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            now_q  <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            now_q  <= now_d;
            prev_q <= prev_d;
        end
    end

    assign sync_now = now_q;
    assign fall_c   = prev_q & ~now_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain clock/data enables.
// Optional watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_err,
    input  logic       kbd_clk,
    input  logic       kbd_dat,
    output logic       kbd_clk_oe,
    output logic       kbd_dat_oe
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned SH_W  = PS2_DATA_BITS + 1;
    localparam int unsigned CNT_W = 4;

    logic clk_sync, clk_fall_c;
    logic dat_sync, unused_dat_fall_c;

    ps2_tx_st_t       state_q, state_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic ack_q, ack_d;
    logic clk_oe_q, clk_oe_d;
    logic dat_oe_q, dat_oe_d;
    logic done_q, done_d;
    logic ack_ok_q, ack_ok_d;
    logic ready_q, ready_d;
    logic busy_q, busy_d;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic err_q, err_d;
`endif

    ps2_line_sync u_clk_sync (
        .clk      (clk),
        .reset    (reset),
        .line_raw (kbd_clk),
        .sync_now (clk_sync),
        .fall_c   (clk_fall_c)
    );

    ps2_line_sync u_dat_sync (
        .clk      (clk),
        .reset    (reset),
        .line_raw (kbd_dat),
        .sync_now (dat_sync),
        .fall_c   (unused_dat_fall_c)
    );

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        inh_d    = inh_q;
        ack_d    = ack_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        ack_ok_d = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        wd_d     = wd_q;
        err_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                dat_oe_d = 1'b0;
                if (din_valid) begin
                    sh_d    = {odd_parity(din), din};
                    cnt_d   = '0;
                    inh_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    state_d  = REQ;
                    dat_oe_d = 1'b1;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                    wd_d     = '0;
`endif
                end else begin
                    inh_d = inh_q + INH_W'(1);
                end
            end
            // Ones shift in behind the frame so the stop fall releases the line
            REQ, DATA: begin
                if (clk_fall_c) begin
                    dat_oe_d = ~sh_q[0];
                    sh_d     = {1'b1, sh_q[SH_W-1:1]};
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (state_q == REQ) begin
                        state_d = DATA;
                    end else if (cnt_q == CNT_W'(PS2_FRAME_BITS - 2)) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall_c) begin
                    ack_d   = ~dat_sync;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && dat_sync) begin
                    done_d   = 1'b1;
                    ack_ok_d = ack_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Completion in the same cycle takes priority over the watchdog
        if (state_q inside {REQ, DATA, ACK, WAIT_IDLE}) begin
            if (!done_d && (wd_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
                state_d  = IDLE;
                dat_oe_d = 1'b0;
                err_d    = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
`endif

        clk_oe_d = (state_d == INHIBIT);
        ready_d  = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            cnt_q    <= '0;
            inh_q    <= '0;
            ack_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            ack_ok_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            inh_q    <= inh_d;
            ack_q    <= ack_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
            ack_ok_q <= ack_ok_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign tx_err = err_q;
`else
    assign tx_err = 1'b0;
`endif

    assign tx_ready   = ready_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_ack_ok  = ack_ok_q;
    assign kbd_clk_oe = clk_oe_q;
    assign kbd_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain device model plus frame-level reference.
module tb_ps2_host_tx;

    localparam int unsigned IC = 40;
    localparam int unsigned TO = 1500;
    localparam int          H  = 12;

    typedef struct {
        logic [7:0] din;
        bit         ack;
        bit         glitch;
        logic [9:0] exp_bits;
        logic       exp_ack;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       tx_ready, tx_busy, tx_done, tx_ack_ok, tx_err;
    logic       kbd_clk_oe, kbd_dat_oe;
    logic       dev_clk, dev_dat;
    logic       kbd_clk, kbd_dat;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_seen;
    int   err_seen;
    logic ack_seen;

    frame_t frames [8];

    // Wired-AND open-drain lines
    assign kbd_clk = dev_clk & ~kbd_clk_oe;
    assign kbd_dat = dev_dat & ~kbd_dat_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (IC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_ack_ok  (tx_ack_ok),
        .tx_err     (tx_err),
        .kbd_clk    (kbd_clk),
        .kbd_dat    (kbd_dat),
        .kbd_clk_oe (kbd_clk_oe),
        .kbd_dat_oe (kbd_dat_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (tx_done === 1'b1) begin
            done_seen++;
            ack_seen = tx_ack_ok;
        end
        if (tx_err === 1'b1) err_seen++;
    endtask

    // Bits as the device sees them on its rising edges: data LSB first, odd parity, stop
    function automatic logic [9:0] ref_bits(input logic [7:0] b);
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    task automatic start_and_inhibit(input logic [7:0] b, input bit glitch);
        int n;
        din       = b;
        din_valid = 1'b1;
        check("ready_before_accept", 32'(tx_ready), 32'd1);
        tick();
        din_valid = 1'b0;
        din       = ~b;
        check("busy_after_accept", 32'(tx_busy), 32'd1);
        check("ready_after_accept", 32'(tx_ready), 32'd0);
        check("clk_oe_after_accept", 32'(kbd_clk_oe), 32'd1);
        n = 0;
        while (kbd_clk_oe === 1'b1 && n < int'(IC) + 20) begin
            n++;
            din_valid = (glitch && n == 10);
            if (din_valid) din = 8'hFF;
            tick();
        end
        din_valid = 1'b0;
        check("inhibit_cycles", 32'(n), 32'(IC));
        check("req_dat_oe", 32'(kbd_dat_oe), 32'd1);
        check("req_clk_released", 32'(kbd_clk_oe), 32'd0);
    endtask

    task automatic run_device(input int nfalls, input bit ack, input bit chk_lat,
                              output logic [9:0] smp);
        smp = '0;
        repeat (H) tick();
        for (int k = 1; k <= nfalls; k++) begin
            logic oe0;
            int   lat;
            oe0     = kbd_dat_oe;
            lat     = 0;
            dev_clk = 1'b0;
            for (int i = 0; i < H; i++) begin
                tick();
                if (lat == 0 && kbd_dat_oe !== oe0) lat = i + 1;
            end
            if (k == 1 && chk_lat) check("fall_to_dat_latency", 32'(lat), 32'd3);
            dev_clk = 1'b1;
            if (k <= 10) smp[k-1] = kbd_dat;
            if (k == 10 && ack) begin
                repeat (H / 2) tick();
                dev_dat = 1'b0;
                repeat (H - H / 2) tick();
            end else begin
                repeat (H) tick();
            end
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
    endtask

    task automatic send_frame(input frame_t f);
        logic [9:0] smp;
        int         t;
        done_seen = 0;
        ack_seen  = ~f.exp_ack;
        start_and_inhibit(f.din, f.glitch);
        run_device(11, f.ack, f.din[0], smp);
        check("frame_bits", 32'(smp), 32'(f.exp_bits));
        t = 0;
        while (done_seen == 0 && t < 50) begin
            tick();
            t++;
        end
        check("done_seen", 32'(done_seen), 32'd1);
        check("ack_ok", 32'(ack_seen), 32'(f.exp_ack));
        tick();
        check("done_width", 32'(tx_done), 32'd0);
        check("ready_after_done", 32'(tx_ready), 32'd1);
        check("done_count", 32'(done_seen), 32'd1);
    endtask

    initial begin
        logic [9:0] smp;
        int         t;
        reset     = 1'b1;
        din_valid = 1'b0;
        din       = 8'h00;
        dev_clk   = 1'b1;
        dev_dat   = 1'b1;
        done_seen = 0;
        err_seen  = 0;
        ack_seen  = 1'b0;

        repeat (3) tick();
        check("rst_clk_oe", 32'(kbd_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(kbd_dat_oe), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_ack_ok", 32'(tx_ack_ok), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        reset = 1'b0;
        tick();

        frames[0] = '{din: 8'hED, ack: 1'b1, glitch: 1'b0, exp_bits: '0, exp_ack: 1'b1};
        frames[1] = '{din: 8'h07, ack: 1'b1, glitch: 1'b0, exp_bits: '0, exp_ack: 1'b1};
        frames[2] = '{din: 8'h02, ack: 1'b0, glitch: 1'b0, exp_bits: '0, exp_ack: 1'b0};
        frames[3] = '{din: 8'hA5, ack: 1'b1, glitch: 1'b1, exp_bits: '0, exp_ack: 1'b1};
        for (int i = 4; i < 8; i++) begin
            frames[i].din    = 8'($urandom_range(0, 255));
            frames[i].ack    = 1'($urandom_range(0, 1));
            frames[i].glitch = 1'($urandom_range(0, 1));
            frames[i].exp_ack = frames[i].ack;
        end
        for (int i = 0; i < 8; i++) frames[i].exp_bits = ref_bits(frames[i].din);

        // Frames run back to back: each request lands the cycle after the previous tx_done
        for (int i = 0; i < 8; i++) send_frame(frames[i]);

        // Reset in the middle of the data phase
        repeat (5) tick();
        done_seen = 0;
        err_seen  = 0;
        start_and_inhibit(8'h3C, 1'b0);
        run_device(4, 1'b0, 1'b0, smp);
        check("partial_bits", 32'(smp[3:0]), 32'h0C);
        reset = 1'b1;
        tick();
        check("midrst_clk_oe", 32'(kbd_clk_oe), 32'd0);
        check("midrst_dat_oe", 32'(kbd_dat_oe), 32'd0);
        reset = 1'b0;
        tick();
        check("midrst_ready", 32'(tx_ready), 32'd1);
        repeat (40) tick();
        check("midrst_no_done", 32'(done_seen), 32'd0);
        check("midrst_no_err", 32'(err_seen), 32'd0);

        // Device never clocks after the request
        start_and_inhibit(8'h55, 1'b0);
        done_seen = 0;
        err_seen  = 0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        t = 0;
        while (err_seen == 0 && t < int'(TO) + 50) begin
            tick();
            t++;
        end
        check("timeout_cycles", 32'(t), 32'(TO));
        check("timeout_clk_oe", 32'(kbd_clk_oe), 32'd0);
        check("timeout_dat_oe", 32'(kbd_dat_oe), 32'd0);
        check("timeout_no_done", 32'(tx_done), 32'd0);
        tick();
        check("err_width", 32'(tx_err), 32'd0);
        check("ready_after_err", 32'(tx_ready), 32'd1);
        check("err_count", 32'(err_seen), 32'd1);
        check("timeout_done_count", 32'(done_seen), 32'd0);
`else
        t = 0;
        repeat (TO + 50) begin
            tick();
            t++;
        end
        check("nowd_err_count", 32'(err_seen), 32'd0);
        check("nowd_still_busy", 32'(tx_busy), 32'd1);
        check("nowd_dat_held", 32'(kbd_dat_oe), 32'd1);
        check("nowd_done_count", 32'(done_seen), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("nowd_ready_after_reset", 32'(tx_ready), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
